// File: rtl/rv32i_fetch_decode_if.sv
// Bundle between the fetch/decode core and its environment: instruction
// memory read port, PC redirect request and the decoded-instruction output.
//
// Signals:
//   mem_addr, mem_rstrb   core -> memory, word address and read strobe
//   mem_rdata             memory -> core, word valid the cycle after the strobe
//   redir_valid, redir_pc environment -> core, PC redirect request and target
//   out_valid, out_ready  decoded-instruction handshake
//   out_pc .. out_funct7  decoded fields
//   halted                core -> environment, SYSTEM instruction consumed
//
// Modports: master = the core, slave = memory / consumer side.
interface rv32i_fetch_decode_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rstrb;
  logic [31:0]       mem_rdata;
  logic              redir_valid;
  logic [31:0]       redir_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic [31:0]       out_imm;
  logic [3:0]        out_class;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [2:0]        out_funct3;
  logic [6:0]        out_funct7;
  logic              halted;

  modport master (
    output mem_addr, mem_rstrb,
    input  mem_rdata,
    input  redir_valid, redir_pc,
    output out_valid,
    input  out_ready,
    output out_pc, out_instr, out_imm, out_class,
    output out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
    output halted
  );

  modport slave (
    input  mem_addr, mem_rstrb,
    output mem_rdata,
    output redir_valid, redir_pc,
    input  out_valid,
    output out_ready,
    input  out_pc, out_instr, out_imm, out_class,
    input  out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
    input  halted
  );
endinterface

// File: rtl/rv32i_fetch_decode.sv
// RV32I instruction fetch and decode front end.
// Fetches one word from a synchronous instruction memory, decodes class,
// immediate and fixed register fields, and presents the result on a
// valid/ready output. A SYSTEM instruction, once consumed, halts the block
// until reset.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   bus        rv32i_fetch_decode_if.master (memory, redirect, decoded output)
//   dbg_state  current FSM state (0 FETCH, 1 WAIT, 2 OUT, 3 HALT)
//
// Output handshake: out_valid is high exactly while an instruction is
// presented; the instruction is consumed on a rising edge where out_valid
// and out_ready are both high. While out_valid=1 and out_ready=0 every out_*
// field holds its value. out_valid does not depend on out_ready.
module rv32i_fetch_decode #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                        clk,
  input  logic                        resetn,
  rv32i_fetch_decode_if.master        bus,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_OUT   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] CLS_ALUREG  = 4'd0;
  localparam logic [3:0] CLS_ALUIMM  = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_STORE   = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_JAL     = 4'd5;
  localparam logic [3:0] CLS_JALR    = 4'd6;
  localparam logic [3:0] CLS_LUI     = 4'd7;
  localparam logic [3:0] CLS_AUIPC   = 4'd8;
  localparam logic [3:0] CLS_FENCE   = 4'd9;
  localparam logic [3:0] CLS_SYSTEM  = 4'd10;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [3:0]  cls;
  logic [31:0] imm;
  logic [31:0] redir_target;
  logic        accept;
  logic        is_system;
  logic        rstrb_c;
  logic        valid_c;
  logic        halted_c;

  // ---------------------------------------------------------------------
  // Decode of the instruction register
  // ---------------------------------------------------------------------
  always_comb begin
    cls = CLS_ILLEGAL;
    imm = 32'h0;
    unique case (instr[6:0])
      7'b0110011: cls = CLS_ALUREG;
      7'b0010011: cls = CLS_ALUIMM;
      7'b0000011: cls = CLS_LOAD;
      7'b0100011: cls = CLS_STORE;
      7'b1100011: cls = CLS_BRANCH;
      7'b1101111: cls = CLS_JAL;
      7'b1100111: cls = CLS_JALR;
      7'b0110111: cls = CLS_LUI;
      7'b0010111: cls = CLS_AUIPC;
      7'b0001111: cls = CLS_FENCE;
      7'b1110011: cls = CLS_SYSTEM;
      default:    cls = CLS_ILLEGAL;
    endcase

    unique case (cls)
      CLS_ALUIMM, CLS_LOAD, CLS_JALR, CLS_FENCE, CLS_SYSTEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      CLS_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      CLS_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
               instr[11:8], 1'b0};
      CLS_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
               instr[30:21], 1'b0};
      CLS_LUI, CLS_AUIPC:
        imm = {instr[31:12], 12'h000};
      default:
        imm = 32'h0;
    endcase
  end

  assign is_system    = (cls == CLS_SYSTEM);
  assign accept       = (state == ST_OUT) && bus.out_ready;
  assign redir_target = bus.redir_pc & 32'hFFFF_FFFC;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_FETCH;
    else         state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // A redirect abandons whatever fetch or presentation is in progress,
  // except that a consumed SYSTEM instruction still halts.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FETCH: state_nxt = bus.redir_valid ? ST_FETCH : ST_WAIT;
      ST_WAIT:  state_nxt = bus.redir_valid ? ST_FETCH : ST_OUT;
      ST_OUT: begin
        if (accept && is_system)           state_nxt = ST_HALT;
        else if (accept || bus.redir_valid) state_nxt = ST_FETCH;
        else                                state_nxt = ST_OUT;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // The strobe is gated by resetn so no read is issued while reset is held;
  // the first strobe lands in the first cycle with resetn=1.
  // ---------------------------------------------------------------------
  always_comb begin
    rstrb_c  = 1'b0;
    valid_c  = 1'b0;
    halted_c = 1'b0;
    unique case (state)
      ST_FETCH: rstrb_c  = resetn;
      ST_OUT:   valid_c  = 1'b1;
      ST_HALT:  halted_c = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------
  // PC and instruction register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc    <= RESET_PC;
      instr <= 32'h0000_0033;
    end else begin
      // A redirect in WAIT drops the word arriving this cycle.
      if (state == ST_WAIT && !bus.redir_valid)
        instr <= bus.mem_rdata;
      if (state != ST_HALT) begin
        if (bus.redir_valid)
          pc <= redir_target;
        else if (accept && !is_system)
          pc <= pc + 32'd4;
      end
    end
  end

  assign bus.mem_addr   = pc[ADDR_W+1:2];
  assign bus.mem_rstrb  = rstrb_c;
  assign bus.out_valid  = valid_c;
  assign bus.halted     = halted_c;
  assign bus.out_pc     = pc;
  assign bus.out_instr  = instr;
  assign bus.out_imm    = imm;
  assign bus.out_class  = cls;
  assign bus.out_rd     = instr[11:7];
  assign bus.out_rs1    = instr[19:15];
  assign bus.out_rs2    = instr[24:20];
  assign bus.out_funct3 = instr[14:12];
  assign bus.out_funct7 = instr[31:25];
  assign dbg_state      = state;

endmodule

// File: doc/rv32i_fetch_decode.md
RV32I_FETCH_DECODE -- requirements
Module: rv32i_fetch_decode

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the word-address width of instruction memory (depth 2^ADDR_W words).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, meaning the byte address of the first fetch after reset.
REQ-003 The block SHALL use reset resetn, synchronous, active-low, and clock clk.
REQ-004 Port clk  input  1  is the rising-edge clock.
REQ-005 Port resetn  input  1  is the synchronous active-low reset.
REQ-006 Port mem_addr  output  ADDR_W  is the instruction memory word address, equal to pc[ADDR_W+1:2].
REQ-007 Port mem_rstrb  output  1  is the read strobe, high only in state FETCH.
REQ-008 Port mem_rdata  input  32  is the instruction word, valid the cycle after mem_rstrb.
REQ-009 Port redir_valid  input  1  is the PC redirect request.
REQ-010 Port redir_pc  input  32  is the redirect byte target.
REQ-011 Port out_valid  output  1  marks a decoded instruction as presented.
REQ-012 Port out_ready  input  1  means the consumer accepts the instruction.
REQ-013 Ports out_pc (32), out_instr (32), out_imm (32), out_class (4), out_rd/out_rs1/out_rs2 (5 each), out_funct3 (3) and out_funct7 (7) are outputs carrying the decoded fields.
REQ-014 Port halted  output  1  is high after a SYSTEM instruction is accepted.

Function
REQ-015 The FSM SHALL have states FETCH, WAIT, OUT and HALT with these transitions:
- FETCH->WAIT unconditionally.
- WAIT->OUT, capturing mem_rdata into the instruction register.
- OUT->FETCH on out_ready, with pc<=pc+4.
- OUT->HALT on out_ready when the class is SYSTEM.
REQ-016 HALT SHALL be exited only by reset, with mem_rstrb=0 and out_valid=0 throughout.
REQ-017 out_valid SHALL be high exactly in state OUT.
REQ-018 All out_* fields SHALL be held stable while out_valid=1 and out_ready=0.
REQ-019 Minimum throughput SHALL be one instruction per 3 cycles.
REQ-020 out_class encoding by opcode instr[6:0] SHALL be:
- 0 ALUreg 0110011; 1 ALUimm 0010011; 2 LOAD 0000011; 3 STORE 0100011;
- 4 BRANCH 1100011; 5 JAL 1101111; 6 JALR 1100111; 7 LUI 0110111;
- 8 AUIPC 0010111; 9 FENCE 0001111; 10 SYSTEM 1110011;
- 15 ILLEGAL for any other opcode.
REQ-021 out_imm selection SHALL be:
- I-imm for ALUimm, LOAD, JALR, FENCE and SYSTEM.
- S-imm for STORE.
- B-imm for BRANCH.
- U-imm {instr[31:12],12'b0} for LUI and AUIPC.
- J-imm for JAL.
- 0 for ALUreg and ILLEGAL.
- All immediates except U-imm are sign-extended from instr[31]; B-imm and J-imm bit 0 is 0.
REQ-022 out_rd, out_rs1, out_rs2, out_funct3 and out_funct7 SHALL be the fixed fields instr[11:7], [19:15], [24:20], [14:12] and [31:25], regardless of class.
REQ-023 ILLEGAL instructions SHALL be presented normally (class 15) and fetch SHALL continue at pc+4.
REQ-024 pc SHALL wrap modulo 2^32, and mem_addr SHALL wrap modulo 2^ADDR_W.
REQ-025 redir_valid in FETCH, WAIT or OUT SHALL set pc<=redir_pc with bits [1:0] forced to 0, move the state to FETCH next cycle, and discard any in-flight read.
REQ-026 redir_valid SHALL be ignored in HALT.
REQ-027 If redir_valid and out_ready are both high in OUT, the handshake SHALL complete (instruction consumed) and the redirect target SHALL win over pc+4.
REQ-028 A SYSTEM instruction accepted together with redir_valid SHALL still enter HALT.

Reset
REQ-029 While resetn=0 at a clock edge, the block SHALL set state=FETCH, pc=RESET_PC, instruction register=32'h00000033, out_valid=0, halted=0 and mem_rstrb=0.
REQ-030 The first mem_rstrb SHALL be in the first cycle with resetn=1.
REQ-031 Reset asserted in any state, including mid-handshake, SHALL override all other inputs.

Verification
REQ-032 Reset release with mem[0]=32'h00000033 and out_ready=1 -> out_valid high in cycle 3, out_pc=0, out_class=0, out_imm=0.
REQ-033 mem[0]=32'hFFF0A103 -> class 2, rd=2, rs1=1, funct3=2, imm=32'hFFFFFFFF; mem[1]=32'hFE000CE3 -> class 4, imm=32'hFFFFFFF8, out_pc=4.
REQ-034 Hold out_ready=0 for 5 cycles in OUT -> all out_* stable, mem_rstrb=0, pc unchanged; then out_ready=1 -> next fetch at pc+4.
REQ-035 redir_valid in WAIT with redir_pc=32'h13 -> the in-flight word is never presented, and the next out_pc=32'h10.
REQ-036 mem word 32'h00100073 accepted -> halted=1 next cycle, mem_rstrb stays 0 for 20+ cycles and redir_valid is ignored; a reset pulse restores fetch from RESET_PC.
REQ-037 With ADDR_W=8, pc=32'h3FC accepted -> next mem_addr=0; mem word 32'h0 -> class 15, imm 0, fetch continues.
